// File: rtl/bit_transmitter_pkg.sv
// Shared types and default timing for the WS2812-style serial line encoder.
package bit_transmitter_pkg;

  typedef enum logic [1:0] {
    RESET_GAP    = 2'd0,
    FIRST_PHASE  = 2'd1,
    SECOND_PHASE = 2'd2
  } state_t;

  localparam logic [15:0] DEF_L_TIME = 16'd80;
  localparam logic [15:0] DEF_S_TIME = 16'd40;
  localparam logic [15:0] DEF_R_TIME = 16'd5000;

endpackage

// File: rtl/bit_transmitter_phase_counter.sv
// Up-counter that runs 0..term while enabled and sits at 0 otherwise; done marks the terminal cycle.
module phase_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [15:0] term,
  output logic [15:0] count,
  output logic        done
);

  assign done = en && (count == term);

  // Wrapping to 0 on done lets the same counter time back-to-back phases.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 16'd1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/bit_transmitter.sv
// Serial line encoder: turns requested bits into long/short high-low pulses with a latch gap between frames.
// state        | meaning
// RESET_GAP    | pin low for R_TIME cycles, then request first bit of a frame
// FIRST_PHASE  | pin high; long for a 1, short for a 0
// SECOND_PHASE | pin low; short for a 1, long for a 0, then request next bit
module bit_transmitter
  import bit_transmitter_pkg::*;
#(
  parameter logic [15:0] L_TIME = DEF_L_TIME,
  parameter logic [15:0] S_TIME = DEF_S_TIME,
  parameter logic [15:0] R_TIME = DEF_R_TIME
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        new_bit_rqst,
  input  logic        bit_to_transmit,
  input  logic        all_bits_shifted,
  output logic        new_frame_rqst,
  output logic        led_stripe_pin,
  output logic        reset_finish_dbg,
  output logic        l_time_wait_dbg,
  output logic        s_time_wait_dbg,
  output logic        l_time_measured_dbg,
  output logic        s_time_measured_dbg,
  output logic [15:0] r_time_cnt_dbg,
  output logic [15:0] l_time_cnt_dbg,
  output logic [15:0] s_time_cnt_dbg
);

  state_t state_q, state_d;
  logic   bit_q, bit_d;
  logic   pin_q;
  logic   r_en, l_en, s_en;
  logic   r_done, l_done, s_done;

  assign r_en = (state_q == RESET_GAP);
  assign l_en = ((state_q == FIRST_PHASE) && bit_q) || ((state_q == SECOND_PHASE) && !bit_q);
  assign s_en = ((state_q == FIRST_PHASE) && !bit_q) || ((state_q == SECOND_PHASE) && bit_q);

  phase_counter u_r_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (r_en),
    .term  (R_TIME - 16'd1),
    .count (r_time_cnt_dbg),
    .done  (r_done)
  );

  phase_counter u_l_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (l_en),
    .term  (L_TIME - 16'd1),
    .count (l_time_cnt_dbg),
    .done  (l_done)
  );

  phase_counter u_s_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (s_en),
    .term  (S_TIME - 16'd1),
    .count (s_time_cnt_dbg),
    .done  (s_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RESET_GAP;
      bit_q   <= 1'b0;
      pin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pin_q   <= (state_d == FIRST_PHASE);
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    new_bit_rqst = 1'b0;
    case (state_q)
      RESET_GAP: begin
        // A frame always carries at least one bit, so all_bits_shifted is not consulted here.
        if (r_done) begin
          new_bit_rqst = 1'b1;
          bit_d        = bit_to_transmit;
          state_d      = FIRST_PHASE;
        end
      end
      FIRST_PHASE: begin
        if (l_done || s_done) begin
          state_d = SECOND_PHASE;
        end
      end
      SECOND_PHASE: begin
        if (l_done || s_done) begin
          new_bit_rqst = 1'b1;
          if (all_bits_shifted) begin
            state_d = RESET_GAP;
          end else begin
            bit_d   = bit_to_transmit;
            state_d = FIRST_PHASE;
          end
        end
      end
      default: state_d = RESET_GAP;
    endcase
  end

  assign led_stripe_pin      = pin_q;
  assign new_frame_rqst      = r_done;
  assign reset_finish_dbg    = r_done;
  assign l_time_wait_dbg     = l_en;
  assign s_time_wait_dbg     = s_en;
  assign l_time_measured_dbg = l_done;
  assign s_time_measured_dbg = s_done;

endmodule

// File: tb/tb_bit_transmitter.sv
// Randomized bench: builds the expected line waveform cycle by cycle from the bit/gap rules.
module tb_bit_transmitter;

  localparam logic [15:0] L_T = 16'd80;
  localparam logic [15:0] S_T = 16'd40;
  localparam logic [15:0] R_T = 16'd150;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bit_to_transmit = 1'b0;
  logic        all_bits_shifted = 1'b0;
  logic        new_bit_rqst, new_frame_rqst, led_stripe_pin, reset_finish_dbg;
  logic        l_time_wait_dbg, s_time_wait_dbg, l_time_measured_dbg, s_time_measured_dbg;
  logic [15:0] r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg;

  always #20 clk = ~clk;

  bit_transmitter #(.L_TIME(L_T), .S_TIME(S_T), .R_TIME(R_T)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .new_bit_rqst        (new_bit_rqst),
    .bit_to_transmit     (bit_to_transmit),
    .all_bits_shifted    (all_bits_shifted),
    .new_frame_rqst      (new_frame_rqst),
    .led_stripe_pin      (led_stripe_pin),
    .reset_finish_dbg    (reset_finish_dbg),
    .l_time_wait_dbg     (l_time_wait_dbg),
    .s_time_wait_dbg     (s_time_wait_dbg),
    .l_time_measured_dbg (l_time_measured_dbg),
    .s_time_measured_dbg (s_time_measured_dbg),
    .r_time_cnt_dbg      (r_time_cnt_dbg),
    .l_time_cnt_dbg      (l_time_cnt_dbg),
    .s_time_cnt_dbg      (s_time_cnt_dbg)
  );

  typedef struct packed {
    logic        pin;
    logic        bit_rqst;
    logic        frame_rqst;
    logic        r_fin;
    logic        l_wait;
    logic        s_wait;
    logic        l_meas;
    logic        s_meas;
    logic [15:0] r_cnt;
    logic [15:0] l_cnt;
    logic [15:0] s_cnt;
  } exp_t;

  exp_t obs;
  assign obs = {led_stripe_pin, new_bit_rqst, new_frame_rqst, reset_finish_dbg,
                l_time_wait_dbg, s_time_wait_dbg, l_time_measured_dbg, s_time_measured_dbg,
                r_time_cnt_dbg, l_time_cnt_dbg, s_time_cnt_dbg};

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   cyc_no = 0;

  task automatic chk(input exp_t e, input string tag);
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_no, obs, e);
  endtask

  task automatic push_gap();
    exp_t e;
    for (int i = 0; i < int'(R_T); i++) begin
      e = '0;
      e.r_cnt = 16'(i);
      if (i == int'(R_T) - 1) begin
        e.bit_rqst = 1'b1;
        e.frame_rqst = 1'b1;
        e.r_fin = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_phase(input logic pin, input logic is_long, input logic rqst_end);
    exp_t e;
    int   len = is_long ? int'(L_T) : int'(S_T);
    for (int i = 0; i < len; i++) begin
      e = '0;
      e.pin = pin;
      if (is_long) begin
        e.l_wait = 1'b1;
        e.l_cnt = 16'(i);
        e.l_meas = (i == len - 1);
      end else begin
        e.s_wait = 1'b1;
        e.s_cnt = 16'(i);
        e.s_meas = (i == len - 1);
      end
      e.bit_rqst = rqst_end && (i == len - 1);
      q.push_back(e);
    end
  endtask

  // Bit 1: long high then short low; bit 0: short high then long low.
  task automatic push_cell(input logic b);
    push_phase(1'b1, b, 1'b0);
    push_phase(1'b0, !b, 1'b1);
  endtask

  initial begin
    exp_t cur;
    exp_t zero = '0;
    logic did_rst = 1'b0;
    logic b, abs_f;
    int   req_cnt = 0;
    int   gaps = 0;

    repeat (3) begin
      @(negedge clk);
      #1;
      chk(zero, "reset_state");
    end
    rstn = 1'b1;
    push_gap();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      cyc_no = cyc;
      #1;
      if (!did_rst && cyc >= 1500 && q[0].pin) begin
        rstn = 1'b0;
        #1;
        chk(zero, "mid_bit_reset");
        repeat (3) begin
          @(negedge clk);
          #1;
          chk(zero, "reset_hold");
        end
        rstn = 1'b1;
        did_rst = 1'b1;
        q.delete();
        push_gap();
        #1;
      end
      cur = q.pop_front();
      chk(cur, cur.frame_rqst ? "gap_end" : (cur.bit_rqst ? "cell_end" : "line"));
      if (cur.bit_rqst) begin
        req_cnt++;
        b = 1'($urandom_range(0, 1));
        abs_f = ($urandom_range(0, 5) == 0) || (req_cnt == 6);
        bit_to_transmit = b;
        all_bits_shifted = abs_f;
        if (cur.frame_rqst || !abs_f) begin
          push_cell(b);
        end else begin
          gaps++;
          push_gap();
        end
      end else begin
        bit_to_transmit = 1'($urandom_range(0, 1));
        all_bits_shifted = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end

    total++;
    assert (did_rst && gaps > 0) passed++;
    else $error("FAIL coverage observed=%0d/%0d expected=1/>0", did_rst, gaps);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
